// File: rtl/dp_pkg.sv
// Shared constants for the phase-1 datapath: ALU op codes plus enable and bus-select bit positions.
package dp_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;
    localparam logic [3:0] ALU_PASS = 4'd13;
    localparam logic [3:0] ALU_RSVD = 4'd14;
    localparam logic [3:0] ALU_INC  = 4'd15;

    localparam int unsigned NUM_GPR = 16;

    localparam int unsigned EN_HI     = 16;
    localparam int unsigned EN_LO     = 17;
    localparam int unsigned EN_Z      = 18;
    localparam int unsigned EN_Y      = 19;
    localparam int unsigned EN_PC     = 20;
    localparam int unsigned EN_MDR    = 21;
    localparam int unsigned EN_MAR    = 22;
    localparam int unsigned EN_IR     = 23;
    localparam int unsigned EN_INPORT = 24;

    localparam int unsigned SEL_HI     = 16;
    localparam int unsigned SEL_LO     = 17;
    localparam int unsigned SEL_ZHI    = 18;
    localparam int unsigned SEL_ZLO    = 19;
    localparam int unsigned SEL_PC     = 20;
    localparam int unsigned SEL_MDR    = 21;
    localparam int unsigned SEL_INPORT = 22;
    localparam int unsigned SEL_C      = 23;
    localparam int unsigned NUM_SRC    = 24;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit {hi, lo} result headed for Z.
module alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         op,
    output logic [2*WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]         amt;
    logic [2*WIDTH-1:0]     rot;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]       hi;
    logic [WIDTH-1:0]       lo;

    assign amt  = b[SHW-1:0];
    assign prod = $signed(a) * $signed(b);

    always_comb begin
        hi  = '0;
        lo  = '0;
        rot = '0;
        case (op)
            ALU_ADD:  lo = a + b;
            ALU_SUB:  lo = a - b;
            ALU_AND:  lo = a & b;
            ALU_OR:   lo = a | b;
            ALU_SHR:  lo = a >> amt;
            ALU_SHRA: lo = $signed(a) >>> amt;
            ALU_SHL:  lo = a << amt;
            // Rotates shift a doubled copy so an amount of zero needs no special case.
            ALU_ROR: begin
                rot = {a, a} >> amt;
                lo  = rot[WIDTH-1:0];
            end
            ALU_ROL: begin
                rot = {a, a} << amt;
                lo  = rot[2*WIDTH-1:WIDTH];
            end
            ALU_MUL: begin
                hi = prod[2*WIDTH-1:WIDTH];
                lo = prod[WIDTH-1:0];
            end
            ALU_DIV: begin
                // Divide by zero leaves 0/0; the one overflowing case (MIN / -1) wraps to MIN, remainder 0.
                if (b != '0) begin
                    if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
                        lo = a;
                    end else begin
                        lo = $signed(a) / $signed(b);
                        hi = $signed(a) % $signed(b);
                    end
                end
            end
            ALU_NEG:  lo = -b;
            ALU_NOT:  lo = ~b;
            ALU_PASS: lo = b;
            ALU_INC:  lo = b + WIDTH'(1);
            default:  lo = '0;
        endcase
    end

    assign result = {hi, lo};

endmodule

// File: rtl/data_path.sv
// Phase-1 CPU datapath: register file, special registers and ALU around a single priority-muxed bus.
module data_path
    import dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      enable,
    input  logic [31:0]      busSelect,
    input  logic [WIDTH-1:0] inPort,
    input  logic [WIDTH-1:0] MDataIn,
    input  logic             MD_Read,
    input  logic [3:0]       Control_Signals,
    output logic [WIDTH-1:0] busMuxOut
);

    logic [WIDTH-1:0]   gpr [NUM_GPR];
    logic [WIDTH-1:0]   hi_reg, lo_reg, y_reg, pc_reg, ir_reg, mar_reg, mdr_reg, in_reg;
    logic [2*WIDTH-1:0] z_reg;
    logic [2*WIDTH-1:0] alu_result;
    logic [WIDTH-1:0]   src [NUM_SRC];
    logic               hit;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (y_reg),
        .b      (busMuxOut),
        .op     (Control_Signals),
        .result (alu_result)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            src[i] = gpr[i];
        end
        src[SEL_HI]     = hi_reg;
        src[SEL_LO]     = lo_reg;
        src[SEL_ZHI]    = z_reg[2*WIDTH-1:WIDTH];
        src[SEL_ZLO]    = z_reg[WIDTH-1:0];
        src[SEL_PC]     = pc_reg;
        src[SEL_MDR]    = mdr_reg;
        src[SEL_INPORT] = in_reg;
        src[SEL_C]      = {{(WIDTH-19){ir_reg[18]}}, ir_reg[18:0]};
    end

    // Lowest asserted select wins; nothing selected drives zero.
    always_comb begin
        busMuxOut = '0;
        hit       = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (busSelect[i] && !hit) begin
                busMuxOut = src[i];
                hit       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
            hi_reg  <= '0;
            lo_reg  <= '0;
            z_reg   <= '0;
            y_reg   <= '0;
            pc_reg  <= '0;
            mdr_reg <= '0;
            mar_reg <= '0;
            ir_reg  <= '0;
            in_reg  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                if (enable[i]) gpr[i] <= busMuxOut;
            end
            if (enable[EN_HI])     hi_reg  <= busMuxOut;
            if (enable[EN_LO])     lo_reg  <= busMuxOut;
            if (enable[EN_Z])      z_reg   <= alu_result;
            if (enable[EN_Y])      y_reg   <= busMuxOut;
            if (enable[EN_PC])     pc_reg  <= busMuxOut;
            if (enable[EN_MDR])    mdr_reg <= MD_Read ? MDataIn : busMuxOut;
            if (enable[EN_MAR])    mar_reg <= busMuxOut;
            if (enable[EN_IR])     ir_reg  <= busMuxOut;
            if (enable[EN_INPORT]) in_reg  <= inPort;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: ALU vector table through Y/Z, plus register-transfer sequences.
module tb_data_path;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [31:0] inPort;
    logic [31:0] MDataIn;
    logic        MD_Read;
    logic [3:0]  Control_Signals;
    logic [31:0] busMuxOut;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] exp;
        string       nm;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } vec_t;
    vec_t vecs [$];

    data_path #(.WIDTH(32)) dut (
        .clk             (clk),
        .clr             (clr),
        .enable          (enable),
        .busSelect       (busSelect),
        .inPort          (inPort),
        .MDataIn         (MDataIn),
        .MD_Read         (MD_Read),
        .Control_Signals (Control_Signals),
        .busMuxOut       (busMuxOut)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] bit1(input int unsigned i);
        return 32'd1 << i;
    endfunction

    // One clock cycle: drive, optionally queue an expected bus value, compare at negedge, then cross the edge.
    task automatic step(input logic [31:0] en, input logic [31:0] sel,
                        input logic chk, input logic [31:0] exp, input string nm);
        sb_t e;
        enable    = en;
        busSelect = sel;
        if (chk) sb.push_back('{exp, nm});
        @(negedge clk);
        if (chk) begin
            e = sb.pop_front();
            checks++;
            if (busMuxOut !== e.exp) begin
                errors++;
                $display("FAIL %s: bus=%h expected=%h", e.nm, busMuxOut, e.exp);
            end
        end
        @(posedge clk);
        #1;
        enable          = '0;
        busSelect       = '0;
        Control_Signals = 4'd0;
        MD_Read         = 1'b0;
    endtask

    task automatic idle(input logic [31:0] en, input logic [31:0] sel);
        step(en, sel, 1'b0, '0, "");
    endtask

    task automatic look(input int unsigned s, input logic [31:0] exp, input string nm);
        step('0, bit1(s), 1'b1, exp, nm);
    endtask

    initial begin
        vecs.push_back('{4'd0,  32'd5,        32'd7,        32'h0,        32'd12,       "add"});
        vecs.push_back('{4'd0,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        "add_wrap"});
        vecs.push_back('{4'd1,  32'd3,        32'd5,        32'h0,        32'hFFFFFFFE, "sub"});
        vecs.push_back('{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, "and"});
        vecs.push_back('{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hFFF0FFF0, "or"});
        vecs.push_back('{4'd4,  32'h80000000, 32'h00000024, 32'h0,        32'h08000000, "shr_amt5"});
        vecs.push_back('{4'd5,  32'h80000000, 32'd4,        32'h0,        32'hF8000000, "shra"});
        vecs.push_back('{4'd6,  32'h00000001, 32'd31,       32'h0,        32'h80000000, "shl"});
        vecs.push_back('{4'd7,  32'h00000001, 32'd1,        32'h0,        32'h80000000, "ror"});
        vecs.push_back('{4'd7,  32'h12345678, 32'd0,        32'h0,        32'h12345678, "ror0"});
        vecs.push_back('{4'd8,  32'h80000001, 32'd4,        32'h0,        32'h00000018, "rol"});
        vecs.push_back('{4'd9,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mul_neg"});
        vecs.push_back('{4'd9,  32'h00010000, 32'h00010000, 32'h00000001, 32'h0,        "mul_big"});
        vecs.push_back('{4'd10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_nega"});
        vecs.push_back('{4'd10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negb"});
        vecs.push_back('{4'd10, 32'd5,        32'd0,        32'h0,        32'h0,        "div_zero"});
        vecs.push_back('{4'd11, 32'd9,        32'd5,        32'h0,        32'hFFFFFFFB, "neg"});
        vecs.push_back('{4'd12, 32'd9,        32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0, "not"});
        vecs.push_back('{4'd13, 32'd9,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, "pass"});
        vecs.push_back('{4'd14, 32'd5,        32'd5,        32'h0,        32'h0,        "reserved"});
        vecs.push_back('{4'd15, 32'd9,        32'hFFFFFFFF, 32'h0,        32'h0,        "inc_wrap"});
        vecs.push_back('{4'd15, 32'd9,        32'h00000041, 32'h0,        32'h00000042, "inc"});

        clr = 1'b1; enable = '0; busSelect = '0; inPort = '0; MDataIn = '0;
        MD_Read = 1'b0; Control_Signals = 4'd0;
        @(posedge clk); #1;
        idle('0, '0);
        clr = 1'b0;

        for (int unsigned i = 0; i < 24; i++) look(i, 32'h0, $sformatf("reset_src%0d", i));

        // ALU table: Y <= a via InPort, then B = b on the bus into Z, then read ZHI/ZLO.
        foreach (vecs[k]) begin
            inPort = vecs[k].a;
            idle(bit1(24), '0);
            inPort = vecs[k].b;
            idle(bit1(19) | bit1(24), bit1(22));
            Control_Signals = vecs[k].op;
            idle(bit1(18), bit1(22));
            look(18, vecs[k].hi, {vecs[k].nm, "_hi"});
            look(19, vecs[k].lo, {vecs[k].nm, "_lo"});
        end

        // Memory load path into R6 and R7, then MUL through HI/LO.
        MDataIn = 32'h2; MD_Read = 1'b1;
        idle(bit1(21), '0);
        idle(bit1(6), bit1(21));
        idle(bit1(7), bit1(21));
        look(6, 32'h2, "load_r6");
        look(7, 32'h2, "load_r7");
        idle(bit1(19), bit1(6));
        Control_Signals = 4'd9;
        idle(bit1(18), bit1(7));
        idle(bit1(17), bit1(19));
        idle(bit1(16), bit1(18));
        look(17, 32'h4, "mul_lo_reg");
        look(16, 32'h0, "mul_hi_reg");

        // Bus priority and empty select.
        inPort = 32'h99;
        idle(bit1(24), '0);
        idle(bit1(7), bit1(22));
        step('0, bit1(6) | bit1(7), 1'b1, 32'h2, "two_sel_6_7");
        step('0, bit1(7) | bit1(22), 1'b1, 32'h99, "two_sel_7_22");
        step('0, '0, 1'b1, 32'h0, "no_sel");

        // Read and write R6 in one cycle: bus carries old value, register keeps it.
        step(bit1(6), bit1(6), 1'b1, 32'h2, "rw_same_bus");
        look(6, 32'h2, "rw_same_reg");

        // Simultaneous enables load the same bus value.
        idle(bit1(3) | bit1(4), bit1(22));
        look(3, 32'h99, "multi_en_r3");
        look(4, 32'h99, "multi_en_r4");

        // PC fetch: MAR <= PC, Z <= PC+1, PC <= Z, MDR <= mem, IR <= MDR.
        Control_Signals = 4'd15;
        idle(bit1(22) | bit1(18), bit1(20));
        look(19, 32'h1, "fetch_zlo");
        idle(bit1(20), bit1(19));
        MDataIn = 32'h7B380000; MD_Read = 1'b1;
        idle(bit1(21), '0);
        idle(bit1(23), bit1(21));
        look(20, 32'h1, "fetch_pc");
        look(21, 32'h7B380000, "fetch_mdr");
        look(23, 32'h0, "fetch_c");

        // Sign extension of C from IR[18].
        inPort = 32'h00040000;
        idle(bit1(24), '0);
        idle(bit1(23), bit1(22));
        look(23, 32'hFFFC0000, "c_signext");

        // Reset mid-operation overrides an enable in the same cycle.
        inPort = 32'h55;
        idle(bit1(24), '0);
        idle(bit1(3), bit1(22));
        look(3, 32'h55, "pre_reset_r3");
        inPort = 32'h77;
        clr = 1'b1;
        idle(bit1(3) | bit1(24), bit1(22));
        clr = 1'b0;
        for (int unsigned i = 0; i < 24; i++) look(i, 32'h0, $sformatf("midreset_src%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
